// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, occupancy count and level flags.
// Optional sticky overflow/underflow flags are built only when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_en, rd_en;

  // Status flags decode straight from the count register
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign dout         = dout_q;
  assign rd_valid     = rd_valid_q;

  // A full FIFO still takes a write when a read frees a slot in the same cycle
  always_comb begin
    wr_en      = wr && (!full || rd);
    rd_en      = rd && !empty;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    dout_d     = dout_q;
    rd_valid_d = rd_en;
    if (wr_en) wptr_d = wptr_q + PTR_W'(1);
    if (rd_en) begin
      rptr_d = rptr_q + PTR_W'(1);
      dout_d = mem_q[rptr_q];
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is never cleared; reset only drops the write issued alongside it
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wptr_q] <= din;
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (wr && full && !rd);
    underflow_d = underflow_q || (rd && empty && !wr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2).
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk, rst, wr, rd;
  logic [7:0] din, dout;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout),
    .rd_valid(rd_valid), .count(count), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         cnt;
    logic       rv;
    logic [7:0] dout;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lvl(input string name, input int cnt);
    check({name, " count"}, 32'(count), 32'(cnt));
    check({name, " empty"}, 32'(empty), 32'(cnt == 0));
    check({name, " full"}, 32'(full), 32'(cnt == 16));
    check({name, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
    check({name, " almost_full"}, 32'(almost_full), 32'(cnt >= 14));
  endtask

  // Drive away from the active edge, sample 1 time unit after it
  task automatic step(input logic r, input logic w, input logic rq, input logic [7:0] d);
    @(negedge clk);
    rst = r; wr = w; rd = rq; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;

    //          rst   wr    rd    din    cnt rv    dout   ovf   unf
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h33, 2, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b1, 8'h22, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 8'h22, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h33, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 8'h44, 1, 1'b0, 8'h33, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 8'h99, 0, 1'b0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_lvl(nm, vecs[i].cnt);
      check({nm, " rd_valid"}, 32'(rd_valid), 32'(vecs[i].rv));
      check({nm, " dout"}, 32'(dout), 32'(vecs[i].dout));
      check({nm, " overflow"}, 32'(overflow), 32'(vecs[i].ovf & ERR_EN));
      check({nm, " underflow"}, 32'(underflow), 32'(vecs[i].unf & ERR_EN));
    end

    // Fill to full, then drain in order
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      check_lvl($sformatf("fill%0d", i), i + 1);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d dout", i), 32'(dout), 32'(i));
      check($sformatf("drain%0d rd_valid", i), 32'(rd_valid), 32'd1);
      check_lvl($sformatf("drain%0d", i), 15 - i);
    end
    idle();
    check("drain idle rd_valid", 32'(rd_valid), 32'd0);
    check("drain idle dout hold", 32'(dout), 32'h0F);

    // Write into a full FIFO with no read is rejected
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b0, 1'b1, 1'b0, 8'hAA);
    check_lvl("ovf", 16);
    check("ovf overflow", 32'(overflow), 32'(ERR_EN));
    check("ovf rd_valid", 32'(rd_valid), 32'd0);
    // Full with wr+rd: oldest out, new data lands in the freed slot
    step(1'b0, 1'b1, 1'b1, 8'hC3);
    check_lvl("fullwr", 16);
    check("fullwr dout", 32'(dout), 32'h40);
    check("fullwr overflow", 32'(overflow), 32'(ERR_EN));
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check($sformatf("ovfdrain%0d", i), 32'(dout), 32'(8'h40 + i));
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("ovfdrain last", 32'(dout), 32'hC3);
    check_lvl("ovfdrain end", 0);

    // Empty with wr+rd: write only
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    check_lvl("emptywr", 1);
    check("emptywr rd_valid", 32'(rd_valid), 32'd0);
    check("emptywr underflow", 32'(underflow), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("emptywr readback", 32'(dout), 32'h55);
    check("emptywr rv", 32'(rd_valid), 32'd1);

    // Steady streaming at count=8 across pointer wraps
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b1, 1'b1, 8'(8 + k));
      check_lvl($sformatf("stream%0d", k), 8);
      check($sformatf("stream%0d dout", k), 32'(dout), 32'(k));
      check($sformatf("stream%0d rv", k), 32'(rd_valid), 32'd1);
      check($sformatf("stream%0d ovf", k), 32'(overflow), 32'd0);
      check($sformatf("stream%0d unf", k), 32'(underflow), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check($sformatf("streamtail%0d", i), 32'(dout), 32'(40 + i));
    end

    // Reset beats simultaneous wr/rd and clears sticky flags
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("pre-rst underflow", 32'(underflow), 32'(ERR_EN));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hE0 + i));
    check_lvl("pre-rst", 5);
    step(1'b1, 1'b1, 1'b1, 8'h99);
    check_lvl("rstprio", 0);
    check("rstprio dout", 32'(dout), 32'h00);
    check("rstprio rd_valid", 32'(rd_valid), 32'd0);
    check("rstprio underflow", 32'(underflow), 32'd0);
    check("rstprio overflow", 32'(overflow), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("post-rst readback", 32'(dout), 32'h77);
    check_lvl("post-rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
